corr_wrapper: RTL and testbench
===============================

# corr_wrapper

Streaming lagged cross-correlator between two AXI-Stream sample sources. Each sample pair (sig1, sig2) is consumed jointly. For every lag k in 0..N_LAGS-1 the block accumulates sig2[n]·sig1[n−k] over a frame; sig2_axis_tlast marks the end of the frame. At frame end the N_LAGS signed sums are emitted on an AXI-Stream master. The block sits between the ADC/DMA sample streams and the detection logic.

## Interface
Parameters:
- DATA_W, 16: signed sample width, both inputs.
- N_LAGS, 8: number of lags, N_LAGS ≥ 1.
- ACC_W, 40: accumulator and output width, ACC_W ≥ 2·DATA_W.

Ports:
- sclk  in  1  the single clock.
- aresetn  in  1  reset, asynchronous and active-high (the port name is kept as in the codebase; asserted = 1).
- sig1_axis_tdata  in  DATA_W  signed reference samples.
- sig1_axis_tvalid  in  1
- sig1_axis_tready  out  1
- sig2_axis_tdata  in  DATA_W  signed data samples.
- sig2_axis_tvalid  in  1
- sig2_axis_tready  out  1
- sig2_axis_tlast  in  1  last sample of the frame.
- corr_axis_tdata  out  ACC_W  signed correlation sum, lag 0 first.
- corr_axis_tvalid  out  1
- corr_axis_tready  in  1
- corr_axis_tlast  out  1  high with lag N_LAGS−1.

## Operation
- States: ACCUM, DRAIN, EMIT.
- In ACCUM, a pair is accepted in a cycle with sig1_tvalid & sig2_tvalid & state==ACCUM.
  - sig1_axis_tready = (state==ACCUM) & sig2_axis_tvalid.
  - sig2_axis_tready = (state==ACCUM) & sig1_axis_tvalid.
  - A lone valid on either input never transfers.
- Delay line d[0..N_LAGS−1]:
  - On accept, d[0]←sig1 and d[k]←d[k−1].
  - The product for lag k uses the incoming sig1 for k=0 and d[k−1] for k>0.
  - The delay line is zeroed at the start of every frame, so lags never span frames.
- Products are full precision, 2·DATA_W signed, registered in one stage. They are then sign-extended and added into acc[k] in the next stage.
- Accumulation wraps modulo 2^ACC_W in two's complement. There is no saturation.
- An accepted pair with tlast=1 is the final pair of the frame and moves the state to DRAIN.
- DRAIN lasts until the last product has been accumulated, then the state moves to EMIT.
- EMIT outputs acc[0] through acc[N_LAGS−1] in order, one word per corr handshake. corr_axis_tlast is high on the last word.
- When the last word has been taken:
  - all accumulators and the delay line clear;
  - the state returns to ACCUM.
- corr_axis_tdata/tlast stay stable while tvalid=1 and tready=0.

## Timing
- Reset values:
  - all readies 0;
  - corr_axis_tvalid 0, corr_axis_tdata 0, corr_axis_tlast 0;
  - accumulators, delay line and pipeline cleared;
  - state ACCUM.
- Reset asserted mid-frame or mid-EMIT discards the partial frame and any unsent results. There is no output on the cycle reset is released.
- Throughput: one pair per cycle in ACCUM.
- Latency from the tlast handshake in cycle T:
  - product registered at T+1;
  - accumulated at T+2;
  - corr_axis_tvalid high at T+3 carrying lag 0.
- Both readies are low from T+1 until the cycle after the final output handshake.
- Back-to-back ready on the output gives N_LAGS words in N_LAGS cycles.
- A frame of one pair with tlast is legal: lag 0 = product, other lags 0.

## Structure
- Package corr_pkg holds:
  - default DATA_W, ACC_W, N_LAGS;
  - the state enum {ACCUM, DRAIN, EMIT}.
- Sub-module corr_lag_mac: one lag's product register plus accumulator, with clear and enable inputs. It is instantiated N_LAGS times in a generate loop.
- The top level holds the handshake logic, the delay line, the FSM and the output mux/counter.

## Test plan
- Zero data: 500 pairs with sig1=0xFFFF and sig2=0x0000, tlast on the 500th. Required: 8 words, all 0, tlast on the 8th, first tvalid 3 cycles after the tlast handshake.
- Negative correlation: a frame of 1012 pairs with sig1=0xFFFF and sig2=0x0001. Required: lag k = −(1012−k), i.e. −1012, −1011, … −1005.
- Handshake gating:
  - sig1_tvalid=1 with sig2_tvalid=0 for 3 cycles: no transfer, sig1_tready=0.
  - sig2_tvalid dropped for 3 cycles mid-frame: sums unchanged versus continuous streaming.
- Output backpressure: corr_axis_tready toggled 1/0 during EMIT. Required: words stable while stalled, order preserved, input readies low throughout EMIT.
- Short frame and reset:
  - a 1-pair frame with sig1=3 and sig2=−2 gives −6, 0, 0, …;
  - reset asserted after 200 pairs of a frame, then a clean frame: only the clean frame's results appear.

Source files
------------

// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared defaults and state encoding for the lagged cross-correlator
package corr_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int N_LAGS_DEF = 8;
    localparam int ACC_W_DEF  = 40;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } corr_state_e;

endpackage

// File: rtl/corr_lag_mac.sv
// rtl/corr_lag_mac.sv - one lag: registered full-precision product plus wrapping accumulator
module corr_lag_mac
    import corr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod_q;
    logic                       prod_vld_q;
    logic signed [ACC_W-1:0]    acc_q;

    // Stage 1 captures the product of an accepted pair; stage 2 folds it into the sum.
    // The size cast on a signed product sign-extends, and the add wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else if (clr_i) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= en_i;
            if (en_i) begin
                prod_q <= a_i * b_i;
            end
            if (prod_vld_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/corr_wrapper.sv
// rtl/corr_wrapper.sv - streaming lagged cross-correlator with framed result output
module corr_wrapper
    import corr_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_LAGS = N_LAGS_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              sclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] sig1_axis_tdata,
    input  logic              sig1_axis_tvalid,
    output logic              sig1_axis_tready,
    input  logic [DATA_W-1:0] sig2_axis_tdata,
    input  logic              sig2_axis_tvalid,
    output logic              sig2_axis_tready,
    input  logic              sig2_axis_tlast,
    output logic [ACC_W-1:0]  corr_axis_tdata,
    output logic              corr_axis_tvalid,
    input  logic              corr_axis_tready,
    output logic              corr_axis_tlast
);

    localparam int IDX_W = (N_LAGS > 1) ? $clog2(N_LAGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAGS - 1);

    corr_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic run_q;
    logic p_last_q, a_last_q;
    logic signed [DATA_W-1:0] dly_q [N_LAGS];
    logic signed [DATA_W-1:0] taps  [N_LAGS];
    logic signed [ACC_W-1:0]  acc   [N_LAGS];
    logic accept, out_fire, last_fire;

    // run_q keeps both readies low while reset is held and on the release cycle.
    assign accept    = run_q && (state_q == ACCUM) && sig1_axis_tvalid && sig2_axis_tvalid;
    assign out_fire  = corr_axis_tvalid && corr_axis_tready;
    assign last_fire = out_fire && (idx_q == LAST_IDX);

    assign sig1_axis_tready = run_q && (state_q == ACCUM) && sig2_axis_tvalid;
    assign sig2_axis_tready = run_q && (state_q == ACCUM) && sig1_axis_tvalid;

    assign corr_axis_tvalid = (state_q == EMIT);
    assign corr_axis_tdata  = (state_q == EMIT) ? acc[idx_q] : '0;
    assign corr_axis_tlast  = (state_q == EMIT) && (idx_q == LAST_IDX);

    // Reference taps: lag 0 sees the incoming sample, lag k the sample k pairs older.
    always_comb begin
        for (int k = 0; k < N_LAGS; k++) begin
            taps[k] = '0;
        end
        taps[0] = sig1_axis_tdata;
        for (int k = 1; k < N_LAGS; k++) begin
            taps[k] = dly_q[k-1];
        end
    end

    // Run enable, delay line and the frame-end tags that track the last product down the pipe.
    always_ff @(posedge sclk or posedge aresetn) begin
        if (aresetn) begin
            run_q    <= 1'b0;
            p_last_q <= 1'b0;
            a_last_q <= 1'b0;
            for (int k = 0; k < N_LAGS; k++) begin
                dly_q[k] <= '0;
            end
        end else begin
            run_q    <= 1'b1;
            p_last_q <= accept && sig2_axis_tlast;
            a_last_q <= p_last_q;
            if (last_fire) begin
                for (int k = 0; k < N_LAGS; k++) begin
                    dly_q[k] <= '0;
                end
            end else if (accept) begin
                dly_q[0] <= sig1_axis_tdata;
                for (int k = 1; k < N_LAGS; k++) begin
                    dly_q[k] <= dly_q[k-1];
                end
            end
        end
    end

    // State and output word index registers.
    always_ff @(posedge sclk or posedge aresetn) begin
        if (aresetn) begin
            state_q <= ACCUM;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: frame end drains the pipe, then results stream out lag 0 first.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ACCUM: begin
                if (accept && sig2_axis_tlast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (a_last_q) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
                idx_d   = '0;
            end
        endcase
    end

    // One multiply-accumulate lane per lag; all lanes clear together after the last word.
    for (genvar k = 0; k < N_LAGS; k++) begin : g_lag
        corr_lag_mac #(
            .DATA_W(DATA_W),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk_i (sclk),
            .rst_i (aresetn),
            .clr_i (last_fire),
            .en_i  (accept),
            .a_i   (sig2_axis_tdata),
            .b_i   (taps[k]),
            .acc_o (acc[k])
        );
    end

endmodule

// File: tb/tb_corr_wrapper.sv
// tb/tb_corr_wrapper.sv - randomized self-checking bench for corr_wrapper
module tb_corr_wrapper;

    localparam int DW = 16;
    localparam int NL = 8;
    localparam int AW = 40;

    logic          sclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] sig1_axis_tdata, sig2_axis_tdata;
    logic          sig1_axis_tvalid, sig1_axis_tready;
    logic          sig2_axis_tvalid, sig2_axis_tready, sig2_axis_tlast;
    logic [AW-1:0] corr_axis_tdata;
    logic          corr_axis_tvalid, corr_axis_tready, corr_axis_tlast;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    logic signed [DW-1:0] s1q[$];
    logic signed [DW-1:0] s2q[$];
    logic [AW-1:0]        exp_q[NL];

    corr_wrapper #(.DATA_W(DW), .N_LAGS(NL), .ACC_W(AW)) dut (
        .sclk             (sclk),
        .aresetn          (aresetn),
        .sig1_axis_tdata  (sig1_axis_tdata),
        .sig1_axis_tvalid (sig1_axis_tvalid),
        .sig1_axis_tready (sig1_axis_tready),
        .sig2_axis_tdata  (sig2_axis_tdata),
        .sig2_axis_tvalid (sig2_axis_tvalid),
        .sig2_axis_tready (sig2_axis_tready),
        .sig2_axis_tlast  (sig2_axis_tlast),
        .corr_axis_tdata  (corr_axis_tdata),
        .corr_axis_tvalid (corr_axis_tvalid),
        .corr_axis_tready (corr_axis_tready),
        .corr_axis_tlast  (corr_axis_tlast)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_const(input int n, input int a, input int b);
        s1q.delete();
        s2q.delete();
        for (int i = 0; i < n; i++) begin
            s1q.push_back(DW'(a));
            s2q.push_back(DW'(b));
        end
    endfunction

    function automatic void build_rand(input int n);
        s1q.delete();
        s2q.delete();
        for (int i = 0; i < n; i++) begin
            s1q.push_back(DW'($urandom));
            s2q.push_back(DW'($urandom));
        end
    endfunction

    // Reference: sum over the frame of sig2[n]*sig1[n-k], wrapped to AW bits.
    function automatic void model();
        longint sum;
        logic [63:0] w;
        for (int k = 0; k < NL; k++) begin
            sum = 0;
            for (int n = k; n < s1q.size(); n++) begin
                sum += longint'(s2q[n]) * longint'(s1q[n-k]);
            end
            w = 64'(sum);
            exp_q[k] = w[AW-1:0];
        end
    endfunction

    task automatic send(input int n_send, input bit gaps, input int hold_at, output longint tl_cyc);
        int  lone_bad = 0;
        int  iter;
        bit  done;
        bit  timeout = 0;
        tl_cyc = 0;
        for (int i = 0; i < n_send; i++) begin
            sig1_axis_tdata = s1q[i];
            sig2_axis_tdata = s2q[i];
            sig2_axis_tlast = (i == s1q.size() - 1);
            if (i == hold_at) begin
                for (int h = 0; h < 3; h++) begin
                    sig1_axis_tvalid = 1'b1;
                    sig2_axis_tvalid = 1'b0;
                    @(negedge sclk);
                    chk("hold_rdy1", 64'(sig1_axis_tready), 64'(0));
                    chk("hold_rdy2", 64'(sig2_axis_tready), 64'(1));
                    @(posedge sclk);
                    #1;
                end
            end
            done = 0;
            iter = 0;
            while (!done && iter < 200) begin
                sig1_axis_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                sig2_axis_tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(negedge sclk);
                if (sig1_axis_tvalid && !sig2_axis_tvalid && sig1_axis_tready) lone_bad++;
                if (sig2_axis_tvalid && !sig1_axis_tvalid && sig2_axis_tready) lone_bad++;
                if (sig1_axis_tvalid && sig2_axis_tvalid && sig1_axis_tready && sig2_axis_tready) begin
                    done = 1;
                    if (sig2_axis_tlast) tl_cyc = cyc;
                end
                @(posedge sclk);
                #1;
                iter++;
            end
            if (!done) timeout = 1;
            if (timeout) break;
        end
        // Keep both valids high so any ready leaking during drain/emit is visible.
        sig1_axis_tvalid = 1'b1;
        sig2_axis_tvalid = 1'b1;
        sig2_axis_tlast  = 1'b0;
        if (gaps) chk("lone_valid_rdy", 64'(lone_bad), 64'(0));
        if (timeout) chk("send_timeout", 64'(1), 64'(0));
    endtask

    task automatic recv(input int bp_mode, input longint tl_cyc);
        int            idx = 0;
        int            iter = 0;
        int            rdy_bad = 0;
        bit            first = 1;
        bit            stalled = 0;
        bit            tg = 1;
        logic [AW-1:0] st_data;
        logic          st_last;
        while (idx < NL && iter < 300) begin
            corr_axis_tready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? tg : 1'($urandom_range(0, 1));
            tg = ~tg;
            @(negedge sclk);
            if (sig1_axis_tready || sig2_axis_tready) rdy_bad++;
            if (corr_axis_tvalid) begin
                if (first) chk("latency", 64'(cyc - tl_cyc), 64'(3));
                first = 0;
                if (stalled) begin
                    chk("stall_data", 64'(corr_axis_tdata), 64'(st_data));
                    chk("stall_last", 64'(corr_axis_tlast), 64'(st_last));
                    stalled = 0;
                end
                if (corr_axis_tready) begin
                    chk($sformatf("lag%0d", idx), 64'(corr_axis_tdata), 64'(exp_q[idx]));
                    chk($sformatf("last%0d", idx), 64'(corr_axis_tlast), 64'(idx == NL - 1));
                    idx++;
                end else begin
                    stalled = 1;
                    st_data = corr_axis_tdata;
                    st_last = corr_axis_tlast;
                end
            end
            @(posedge sclk);
            #1;
            iter++;
        end
        sig1_axis_tvalid = 1'b0;
        sig2_axis_tvalid = 1'b0;
        corr_axis_tready = 1'b0;
        chk("rdy_low_drain_emit", 64'(rdy_bad), 64'(0));
        if (idx < NL) chk("recv_timeout", 64'(idx), 64'(NL));
    endtask

    task automatic run_frame(input bit gaps, input int hold_at, input int bp_mode);
        longint tl;
        model();
        send(s1q.size(), gaps, hold_at, tl);
        recv(bp_mode, tl);
    endtask

    initial begin
        longint dummy;
        aresetn          = 1'b1;
        sig1_axis_tdata  = '0;
        sig2_axis_tdata  = '0;
        sig1_axis_tvalid = 1'b1;
        sig2_axis_tvalid = 1'b1;
        sig2_axis_tlast  = 1'b0;
        corr_axis_tready = 1'b1;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        chk("rst_rdy1", 64'(sig1_axis_tready), 64'(0));
        chk("rst_rdy2", 64'(sig2_axis_tready), 64'(0));
        chk("rst_vld", 64'(corr_axis_tvalid), 64'(0));
        chk("rst_data", 64'(corr_axis_tdata), 64'(0));
        chk("rst_last", 64'(corr_axis_tlast), 64'(0));
        @(posedge sclk);
        #1;
        aresetn          = 1'b0;
        sig1_axis_tvalid = 1'b0;
        sig2_axis_tvalid = 1'b0;
        @(negedge sclk);
        chk("rel_vld", 64'(corr_axis_tvalid), 64'(0));
        @(posedge sclk);
        #1;

        build_const(500, -1, 0);
        run_frame(0, -1, 0);

        build_const(1012, -1, 1);
        run_frame(0, -1, 0);

        build_rand(50);
        run_frame(0, 25, 0);

        build_rand(40);
        run_frame(0, -1, 1);

        build_const(1, 3, -2);
        run_frame(0, -1, 0);

        // Partial frame killed by reset, then a clean frame.
        build_rand(300);
        send(200, 0, -1, dummy);
        sig1_axis_tvalid = 1'b0;
        sig2_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        @(negedge sclk);
        chk("mid_rst_rdy1", 64'(sig1_axis_tready), 64'(0));
        chk("mid_rst_vld", 64'(corr_axis_tvalid), 64'(0));
        @(posedge sclk);
        #1;
        aresetn = 1'b0;
        @(negedge sclk);
        chk("mid_rel_vld", 64'(corr_axis_tvalid), 64'(0));
        @(posedge sclk);
        #1;
        build_rand(30);
        run_frame(0, -1, 0);

        for (int r = 0; r < 6; r++) begin
            build_rand(int'($urandom_range(1, 60)));
            run_frame(1, -1, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
